// File: rtl/tile_raster_engine.sv
// Tile rasteriser: clips each triangle's bounding box to the tile, streams covered pixels
// through an external pixel calculator and writes results back; also clear-fills the tile.
module tile_raster_engine #(
  parameter  int MAX_TRIANGLES = 256,
  parameter  int TILE_W        = 20,
  parameter  int TILE_H        = 45,
  parameter  int PIX_W         = 32,
  parameter  int CALC_LAT      = 2,
  localparam int TW            = $clog2(MAX_TRIANGLES),
  localparam int AW            = $clog2(TILE_W*TILE_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [PIX_W-1:0] clear_value,
  input  logic [TW:0]      num_triangles,
  input  logic [8:0]       x_offset,
  input  logic [7:0]       y_offset,
  output logic [TW-1:0]    tri_rd_addr,
  input  logic [127:0]     tri_rd_data,
  output logic [AW-1:0]    tile_rd_addr,
  input  logic [PIX_W-1:0] tile_rd_data,
  output logic             calc_valid,
  output logic [8:0]       calc_x,
  output logic [7:0]       calc_y,
  output logic [PIX_W-1:0] calc_pix,
  output logic [127:0]     calc_tri,
  input  logic             calc_out_valid,
  input  logic [PIX_W-1:0] calc_out_pix,
  output logic             tile_wr_en,
  output logic [AW-1:0]    tile_wr_addr,
  output logic [PIX_W-1:0] tile_wr_data,
  output logic             busy,
  output logic             done
);

  localparam int NPIX = TILE_W * TILE_H;
  localparam int D    = CALC_LAT + 2;
  localparam int CW   = $clog2((TILE_W > TILE_H) ? TILE_W : TILE_H);
  localparam int DCW  = $clog2(D + 1);
  localparam logic signed [16:0] XLAST = 17'(TILE_W - 1);
  localparam logic signed [16:0] YLAST = 17'(TILE_H - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_CLIP, S_ITER, S_DRAIN, S_NEXT, S_CLEAR, S_FINISH
  } state_t;

  state_t             r_state;
  logic [TW:0]        r_num, r_idx;
  logic [TW-1:0]      r_tri_addr;
  logic [8:0]         r_xo;
  logic [7:0]         r_yo;
  logic [127:0]       r_tri;
  logic [CW-1:0]      r_lx, r_hx, r_ly, r_hy, r_cx, r_cy;
  logic [DCW-1:0]     r_cnt;
  logic               r_clr_en;
  logic [AW-1:0]      r_clr_addr;
  logic [PIX_W-1:0]   r_clr_data;
  logic               r_done;
  logic               r_rd_v;
  logic [AW-1:0]      r_rd_addr;
  logic [8:0]         r_ix;
  logic [7:0]         r_iy;
  logic               r_pv [D];
  logic [AW-1:0]      r_pa [D];
  logic [8:0]         r_px [2];
  logic [7:0]         r_py [2];

  logic signed [16:0] w_x1, w_y1, w_x2, w_y2, w_x3, w_y3;
  logic signed [16:0] w_xo, w_yo, w_lx, w_hx, w_ly, w_hy;
  logic               w_empty;
  logic [TW:0]        w_idx_nxt;
  logic [AW-1:0]      w_iaddr;
  logic               w_wr_pix;

  function automatic logic signed [16:0] smin(input logic signed [16:0] a, input logic signed [16:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [16:0] smax(input logic signed [16:0] a, input logic signed [16:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    w_x1 = {tri_rd_data[111], tri_rd_data[111:96]};
    w_y1 = {tri_rd_data[95],  tri_rd_data[95:80]};
    w_x2 = {tri_rd_data[79],  tri_rd_data[79:64]};
    w_y2 = {tri_rd_data[63],  tri_rd_data[63:48]};
    w_x3 = {tri_rd_data[47],  tri_rd_data[47:32]};
    w_y3 = {tri_rd_data[31],  tri_rd_data[31:16]};
    w_xo = {8'd0, r_xo};
    w_yo = {9'd0, r_yo};
    // Box is clipped in screen space, then rebased to tile-local coordinates.
    w_lx = smax(smin(smin(w_x1, w_x2), w_x3), w_xo) - w_xo;
    w_hx = smin(smax(smax(w_x1, w_x2), w_x3), w_xo + XLAST) - w_xo;
    w_ly = smax(smin(smin(w_y1, w_y2), w_y3), w_yo) - w_yo;
    w_hy = smin(smax(smax(w_y1, w_y2), w_y3), w_yo + YLAST) - w_yo;
    w_empty   = (w_lx > w_hx) || (w_ly > w_hy);
    w_idx_nxt = r_idx + 1'b1;
    w_iaddr   = AW'(int'(r_cy) * TILE_W + int'(r_cx));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_num      <= '0;
      r_idx      <= '0;
      r_tri_addr <= '0;
      r_xo       <= '0;
      r_yo       <= '0;
      r_tri      <= '0;
      r_lx       <= '0;
      r_hx       <= '0;
      r_ly       <= '0;
      r_hy       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_cnt      <= '0;
      r_clr_en   <= 1'b0;
      r_clr_addr <= '0;
      r_clr_data <= '0;
      r_done     <= 1'b0;
      r_rd_v     <= 1'b0;
      r_rd_addr  <= '0;
      r_ix       <= '0;
      r_iy       <= '0;
    end else begin
      r_done <= 1'b0;
      r_rd_v <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_clr_en   <= 1'b1;
            r_clr_addr <= '0;
            r_clr_data <= clear_value;
            r_state    <= S_CLEAR;
          end else if (start) begin
            r_num      <= num_triangles;
            r_xo       <= x_offset;
            r_yo       <= y_offset;
            r_idx      <= '0;
            r_tri_addr <= '0;
            r_state    <= (num_triangles == '0) ? S_FINISH : S_FETCH1;
          end
        end
        S_FETCH1: r_state <= S_FETCH2;
        S_FETCH2: r_state <= S_CLIP;
        S_CLIP: begin
          r_tri <= tri_rd_data;
          r_lx  <= CW'(w_lx);
          r_hx  <= CW'(w_hx);
          r_ly  <= CW'(w_ly);
          r_hy  <= CW'(w_hy);
          r_cx  <= CW'(w_lx);
          r_cy  <= CW'(w_ly);
          r_state <= w_empty ? S_NEXT : S_ITER;
        end
        S_ITER: begin
          r_rd_v    <= 1'b1;
          r_rd_addr <= w_iaddr;
          r_ix      <= r_xo + 9'(r_cx);
          r_iy      <= r_yo + 8'(r_cy);
          if (r_cx == r_hx) begin
            r_cx <= r_lx;
            if (r_cy == r_hy) begin
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_cy <= r_cy + 1'b1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == DCW'(D - 1)) r_state <= S_NEXT;
          else                      r_cnt   <= r_cnt + 1'b1;
        end
        S_NEXT: begin
          if (w_idx_nxt == r_num) begin
            r_state <= S_FINISH;
          end else begin
            r_idx      <= w_idx_nxt;
            r_tri_addr <= TW'(w_idx_nxt);
            r_state    <= S_FETCH1;
          end
        end
        S_CLEAR: begin
          if (r_clr_addr == AW'(NPIX - 1)) begin
            r_clr_en <= 1'b0;
            r_state  <= S_FINISH;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-to-write pipeline: stage 1 meets tile_rd_data, stage D-1 meets calc_out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < D; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
      end
      for (int unsigned i = 0; i < 2; i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
      end
    end else begin
      r_pv[0] <= r_rd_v;
      r_pa[0] <= r_rd_addr;
      r_px[0] <= r_ix;
      r_py[0] <= r_iy;
      r_px[1] <= r_px[0];
      r_py[1] <= r_py[0];
      for (int unsigned i = 1; i < D; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

  assign w_wr_pix     = calc_out_valid & r_pv[D-1];
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign tri_rd_addr  = r_tri_addr;
  assign tile_rd_addr = r_rd_addr;
  assign calc_valid   = r_pv[1];
  assign calc_x       = r_px[1];
  assign calc_y       = r_py[1];
  assign calc_pix     = r_pv[1] ? tile_rd_data : '0;
  assign calc_tri     = r_tri;
  assign tile_wr_en   = r_clr_en | w_wr_pix;
  assign tile_wr_addr = r_clr_en ? r_clr_addr : r_pa[D-1];
  assign tile_wr_data = r_clr_en ? r_clr_data : (w_wr_pix ? calc_out_pix : '0);

endmodule
